// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: divide FSM states and
// E-stage forwarding select encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivBusy = 2'd1,
        DivDone = 2'd2
    } div_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one E-stage source operand; M result beats W result.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] write_reg_m_i,
    input  logic       reg_write_en_m_i,
    input  logic [4:0] write_reg_w_i,
    input  logic       reg_write_en_w_i,
    output logic [1:0] sel_o
);

    logic hit_m;
    logic hit_w;

    // $0 is hardwired zero, so a write to it never produces a forwardable value
    assign hit_m = reg_write_en_m_i & (write_reg_m_i != 5'd0) & (write_reg_m_i == src_i);
    assign hit_w = reg_write_en_w_i & (write_reg_w_i != 5'd0) & (write_reg_w_i == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (hit_m) begin
            sel_o = FWD_M;
        end else if (hit_w) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage pipeline: sequences cache
// freezes, M-stage exceptions, multi-cycle divide, load-use and branch mispredict.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] write_regE,
    input  logic [4:0] write_regM,
    input  logic [4:0] write_regW,
    input  logic       reg_write_enE,
    input  logic       reg_write_enM,
    input  logic       reg_write_enW,
    input  logic       mem_read_enE,
    input  logic       div_startE,
    input  logic       div_done,
    input  logic       pred_wrongE,
    input  logic       except_M,
    input  logic       i_stall,
    input  logic       d_stall,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       div_busy
);

    div_state_e state_q, state_d;
    logic       exc_pend_q, exc_pend_d;
    logic       br_pend_q, br_pend_d;

    logic       freeze;
    logic       exc;
    logic       stall_div;
    logic       lu;
    logic       br_req;
    logic [4:0] stall_vec;  // {F, D, E, M, W}
    logic [3:0] flush_vec;  // {D, E, M, W}

    assign freeze    = i_stall | d_stall;
    assign exc       = except_M | exc_pend_q;
    assign stall_div = ((state_q == DivIdle) & div_startE) | ((state_q == DivBusy) & ~div_done);
    assign lu        = mem_read_enE & reg_write_enE & (write_regE != 5'd0)
                     & ((write_regE == rsD) | (write_regE == rtD));
    assign br_req    = pred_wrongE | br_pend_q;

    always_comb begin
        stall_vec = '0;
        flush_vec = '0;
        if (!rst) begin
            if (freeze) begin
                stall_vec = 5'b11111;
            end else if (exc) begin
                flush_vec = 4'b1111;
            end else begin
                if (stall_div) begin
                    stall_vec = stall_vec | 5'b11100;
                    flush_vec = flush_vec | 4'b0010;
                end
                if (lu) begin
                    stall_vec = stall_vec | 5'b11000;
                    // a divide holding E owns that register; never bubble over it
                    if (!stall_div) begin
                        flush_vec = flush_vec | 4'b0100;
                    end
                end
                if (br_req && !stall_vec[3]) begin
                    flush_vec = flush_vec | 4'b1000;
                end
            end
        end
    end

    assign {stallF, stallD, stallE, stallM, stallW} = stall_vec;
    assign {flushD, flushE, flushM, flushW}         = flush_vec;
    assign div_busy = ~rst & (state_q != DivIdle);

    always_comb begin
        state_d    = state_q;
        exc_pend_d = exc_pend_q;
        br_pend_d  = br_pend_q;
        if (exc && !freeze) begin
            state_d    = DivIdle;
            exc_pend_d = 1'b0;
            br_pend_d  = 1'b0;
        end else begin
            exc_pend_d = freeze & (exc_pend_q | except_M);
            // redirect waits until the delay slot can actually leave D
            br_pend_d  = stall_vec[3] & br_req;
            case (state_q)
                DivIdle: begin
                    if (div_startE && !freeze) begin
                        state_d = DivBusy;
                    end
                end
                DivBusy: begin
                    if (div_done) begin
                        state_d = freeze ? DivDone : DivIdle;
                    end
                end
                DivDone: begin
                    if (!freeze) begin
                        state_d = DivIdle;
                    end
                end
                default: state_d = DivIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivIdle;
            exc_pend_q <= 1'b0;
            br_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exc_pend_q <= exc_pend_d;
            br_pend_q  <= br_pend_d;
        end
    end

    fwd_unit u_fwd_a (
        .src_i           (rsE),
        .write_reg_m_i   (write_regM),
        .reg_write_en_m_i(reg_write_enM),
        .write_reg_w_i   (write_regW),
        .reg_write_en_w_i(reg_write_enW),
        .sel_o           (forwardAE)
    );

    fwd_unit u_fwd_b (
        .src_i           (rtE),
        .write_reg_m_i   (write_regM),
        .reg_write_en_m_i(reg_write_enM),
        .write_reg_w_i   (write_regW),
        .reg_write_en_w_i(reg_write_enW),
        .sel_o           (forwardBE)
    );

endmodule
